// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_pkg : state, opcode and control-word types for mc_controller.
// Optional macro: MC_CTRL_ILLEGAL_TRAP_EN. Revision: 1.0
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , S_TRAP  = 4'd12
`endif
   } statetype;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef struct packed {
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
   } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_controller_if : opcode/handshake inputs and datapath controls.
// Optional macro: MC_CTRL_ILLEGAL_TRAP_EN. Revision: 1.0
// ---------------------------------------------------------------------------
interface mc_controller_if;
   logic [5:0] op;
   logic       mem_ready;
   logic       iord;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsrc;
   logic       irwrite;
   logic       pcwrite;
   logic       branch;
   logic       memwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   modport master (
      input  op, mem_ready,
      output iord, alusrca, alusrcb, aluop, pcsrc, irwrite, pcwrite,
             branch, memwrite, regwrite, regdst, memtoreg, state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , output illegal_op
`endif
   );

   modport slave (
      output op, mem_ready,
      input  iord, alusrca, alusrcb, aluop, pcsrc, irwrite, pcwrite,
             branch, memwrite, regwrite, regdst, memtoreg, state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , input illegal_op
`endif
   );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_outdec : combinational state -> control word decoder (Moore).
// Revision: 1.0
// ---------------------------------------------------------------------------
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  statetype   state,
   output ctrl_word_t cw
);
   always_comb begin
      cw = '0;
      case (state)
         S_FETCH: begin
            cw.alusrcb = 2'b01;
            cw.irwrite = 1'b1;
            cw.pcwrite = 1'b1;
         end
         // Branch target is precomputed into ALUOut while decoding.
         S_DECODE:  cw.alusrcb = 2'b11;
         S_MEMADR: begin
            cw.alusrca = 1'b1;
            cw.alusrcb = 2'b10;
         end
         S_MEMRD:   cw.iord = 1'b1;
         S_MEMWB: begin
            cw.memtoreg = 1'b1;
            cw.regwrite = 1'b1;
         end
         S_MEMWR: begin
            cw.iord     = 1'b1;
            cw.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            cw.alusrca = 1'b1;
            cw.aluop   = 2'b10;
         end
         S_RTYPEWB: begin
            cw.regdst   = 1'b1;
            cw.regwrite = 1'b1;
         end
         S_BEQEX: begin
            cw.alusrca = 1'b1;
            cw.aluop   = 2'b01;
            cw.pcsrc   = 2'b01;
            cw.branch  = 1'b1;
         end
         S_ADDIEX: begin
            cw.alusrca = 1'b1;
            cw.alusrcb = 2'b10;
         end
         S_ADDIWB:  cw.regwrite = 1'b1;
         S_JEX: begin
            cw.pcsrc   = 2'b10;
            cw.pcwrite = 1'b1;
         end
         default:   cw = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_controller : multicycle MIPS control FSM with memory-ready stalls.
// Optional macro: MC_CTRL_ILLEGAL_TRAP_EN. Revision: 1.0
// ---------------------------------------------------------------------------
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       reset_n,
   mc_controller_if.master bus
);
   statetype   r_state;
   ctrl_word_t w_cw;
   logic       w_fetch;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (bus.op)
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_RTYPE:     r_state <= S_RTYPEEX;
                  OP_BEQ:       r_state <= S_BEQEX;
                  OP_ADDI:      r_state <= S_ADDIEX;
                  OP_J:         r_state <= S_JEX;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  default:      r_state <= S_TRAP;
`else
                  default:      r_state <= S_FETCH;
`endif
               endcase
            end
            S_MEMADR:  r_state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (bus.mem_ready) r_state <= S_MEMWB;
            S_MEMWR:   if (bus.mem_ready) r_state <= S_FETCH;
            S_RTYPEEX: r_state <= S_RTYPEWB;
            S_ADDIEX:  r_state <= S_ADDIWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:    r_state <= S_TRAP;
`endif
            default:   r_state <= S_FETCH;
         endcase
      end
   end

   mc_ctrl_outdec u_outdec (
      .state (r_state),
      .cw    (w_cw)
   );

   // Fetch writes only land once memory has returned the instruction.
   assign w_fetch      = (r_state == S_FETCH);
   assign bus.irwrite  = w_cw.irwrite & (!w_fetch | bus.mem_ready);
   assign bus.pcwrite  = w_cw.pcwrite & (!w_fetch | bus.mem_ready);
   assign bus.iord     = w_cw.iord;
   assign bus.alusrca  = w_cw.alusrca;
   assign bus.alusrcb  = w_cw.alusrcb;
   assign bus.aluop    = w_cw.aluop;
   assign bus.pcsrc    = w_cw.pcsrc;
   assign bus.branch   = w_cw.branch;
   assign bus.memwrite = w_cw.memwrite;
   assign bus.regwrite = w_cw.regwrite;
   assign bus.regdst   = w_cw.regdst;
   assign bus.memtoreg = w_cw.memtoreg;
   assign bus.state    = r_state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign bus.illegal_op = (r_state == S_TRAP);
`endif
endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_controller : directed self-checking bench for mc_controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mc_controller;
   localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3,
                          MB = 4'd4, MW = 4'd5, RE = 4'd6, RB = 4'd7,
                          BQ = 4'd8, AE = 4'd9, AB = 4'd10, JX = 4'd11,
                          TR = 4'd12;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   mc_controller_if bus ();

   mc_controller dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   // {iord, alusrca, alusrcb, aluop, pcsrc, irwrite, pcwrite, branch,
   //  memwrite, regwrite, regdst, memtoreg}, FETCH with mem_ready=1
   function automatic logic [14:0] exp_cw(input logic [3:0] s);
      case (s)
         FE: return 15'b0_0_01_00_00_1100000;
         DE: return 15'b0_0_11_00_00_0000000;
         MA: return 15'b0_1_10_00_00_0000000;
         MR: return 15'b1_0_00_00_00_0000000;
         MB: return 15'b0_0_00_00_00_0000101;
         MW: return 15'b1_0_00_00_00_0001000;
         RE: return 15'b0_1_00_10_00_0000000;
         RB: return 15'b0_0_00_00_00_0000110;
         BQ: return 15'b0_1_00_01_01_0010000;
         AE: return 15'b0_1_10_00_00_0000000;
         AB: return 15'b0_0_00_00_00_0000100;
         JX: return 15'b0_0_00_00_10_0100000;
         default: return 15'b0;
      endcase
   endfunction

   function automatic logic [14:0] obs_cw();
      return {bus.iord, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc,
              bus.irwrite, bus.pcwrite, bus.branch, bus.memwrite,
              bus.regwrite, bus.regdst, bus.memtoreg};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Runs one instruction with mem_ready=1, checking state and control word
   // every cycle, then checks it is back in FETCH after exactly n cycles.
   task automatic run(input string tag, input logic [5:0] o, input int n,
                      input logic [3:0] s0, s1, s2, s3, s4);
      logic [3:0] seq [5];
      seq = '{s0, s1, s2, s3, s4};
      bus.op = o;
      #1;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_st%0d", tag, i), 32'(bus.state), 32'(seq[i]));
         chk($sformatf("%s_cw%0d", tag, i), 32'(obs_cw()), 32'(exp_cw(seq[i])));
         tick();
      end
      chk($sformatf("%s_end", tag), 32'(bus.state), 32'(FE));
   endtask

   logic [3:0] slow_st [7] = '{FE, DE, MA, MR, MR, MR, MB};
   logic       slow_mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic       slow_rw [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      bus.op = 6'b000010;
      bus.mem_ready = 1'b0;
      tick();
      tick();
      chk("rst_state", 32'(bus.state), 32'(FE));
      chk("rst_cw", 32'(obs_cw()), 32'(15'b0_0_01_00_00_0000000));

      // Release with memory not ready: fetch must not complete
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall_st%0d", i), 32'(bus.state), 32'(FE));
         chk($sformatf("stall_wr%0d", i), 32'({bus.irwrite, bus.pcwrite}), 32'(0));
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      chk("stall_rdy_wr", 32'({bus.irwrite, bus.pcwrite}), 32'(3));
      tick();
      chk("stall_decode", 32'(bus.state), 32'(DE));
      tick();
      tick();
      chk("stall_drain", 32'(bus.state), 32'(FE));

      run("rtype", 6'b000000, 4, FE, DE, RE, RB, FE);
      run("lw",    6'b100011, 5, FE, DE, MA, MR, MB);
      run("sw",    6'b101011, 4, FE, DE, MA, MW, FE);
      run("beq",   6'b000100, 3, FE, DE, BQ, FE, FE);
      run("addi",  6'b001000, 4, FE, DE, AE, AB, FE);
      run("j",     6'b000010, 3, FE, DE, JX, FE, FE);

      // Slow memory on a load: two wait cycles in MEMRD
      bus.op = 6'b100011;
      for (int i = 0; i < 7; i++) begin
         bus.mem_ready = slow_mr[i];
         #1;
         chk($sformatf("slow_st%0d", i), 32'(bus.state), 32'(slow_st[i]));
         chk($sformatf("slow_rw%0d", i), 32'(bus.regwrite), 32'(slow_rw[i]));
         tick();
      end
      chk("slow_end", 32'(bus.state), 32'(FE));

      // Opcode changes while the load is in MEMRD: path is unaffected
      bus.op = 6'b100011;
      tick();
      tick();
      tick();
      chk("opchg_memrd", 32'(bus.state), 32'(MR));
      bus.op = 6'b000000;
      tick();
      chk("opchg_memwb", 32'(bus.state), 32'(MB));
      tick();
      chk("opchg_fetch", 32'(bus.state), 32'(FE));

      // Reset asserted in the middle of a stalled store
      bus.op = 6'b101011;
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      chk("rstsw_st", 32'(bus.state), 32'(MW));
      chk("rstsw_mw1", 32'(bus.memwrite), 32'(1));
      tick();
      chk("rstsw_hold", 32'(bus.state), 32'(MW));
      reset_n = 1'b0;
      #1;
      chk("rstsw_mw0", 32'(bus.memwrite), 32'(0));
      chk("rstsw_fetch", 32'(bus.state), 32'(FE));
      tick();
      reset_n = 1'b1;
      bus.mem_ready = 1'b1;
      #1;

      // Undefined opcode
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      bus.op = 6'b111111;
      tick();
      chk("ill_decode", 32'(bus.state), 32'(DE));
      tick();
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("trap_st%0d", i), 32'(bus.state), 32'(TR));
         chk($sformatf("trap_ill%0d", i), 32'(bus.illegal_op), 32'(1));
         chk($sformatf("trap_cw%0d", i), 32'(obs_cw()), 32'(0));
         tick();
      end
      reset_n = 1'b0;
      #1;
      chk("trap_rst", 32'(bus.state), 32'(FE));
      chk("trap_rst_ill", 32'(bus.illegal_op), 32'(0));
      tick();
      reset_n = 1'b1;
      #1;
`else
      run("ill", 6'b111111, 2, FE, DE, FE, FE, FE);
`endif
      run("post", 6'b001000, 4, FE, DE, AE, AB, FE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS core: a Moore FSM that sequences the shared ALU, the unified instruction/data memory and the register file over 3–5 cycles per instruction. It decodes the same opcode subset as the single-cycle main decoder: R-type, LW, SW, BEQ, ADDI and J. It sits between the instruction register's opcode field and the multicycle datapath. A memory-ready handshake stretches the fetch and memory states.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- `clk` — input, 1 — single clock, rising edge.
- `reset_n` — input, 1 — asynchronous, active-low reset.
- `op` — input, 6 — opcode from the instruction register, instr[31:26].
- `mem_ready` — input, 1 — memory has completed the current access this cycle.
- `iord` — output, 1 — memory address source: 0 = PC, 1 = ALUOut.
- `alusrca` — output, 1 — ALU A source: 0 = PC, 1 = register A.
- `alusrcb` — output, 2 — ALU B source: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `aluop` — output, 2 — 00 = add, 01 = sub, 10 = decode funct.
- `pcsrc` — output, 2 — next-PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `irwrite`, `pcwrite`, `branch`, `memwrite`, `regwrite` — outputs, 1 each — write and branch enables.
- `regdst`, `memtoreg` — outputs, 1 each — register-file write-address and write-data select.
- `state` — output, 4 — current state encoding, for debug.
- `illegal_op` — output, 1 — high in TRAP state; exists only with `MC_CTRL_ILLEGAL_TRAP_EN`.

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, TRAP.

Outputs per state. Signals not listed are 0; `alusrcb`, `aluop` and `pcsrc` default to 00.
- FETCH: `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00. `irwrite` = `pcwrite` = `mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE: `alusrcb`=11 (branch target precompute). Next state by `op`:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - any other value → see Configuration.
- MEMADR: `alusrca`=1, `alusrcb`=10. Goes to MEMRD if `op`=LW, else MEMWR.
- MEMRD: `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. Goes to FETCH.
- MEMWR: `iord`=1, `memwrite`=1, held for the whole state. Holds until `mem_ready`, then goes to FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10. Goes to RTYPEWB.
- RTYPEWB: `regdst`=1, `regwrite`=1. Goes to FETCH.
- BEQEX: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1. Goes to FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10. Goes to ADDIWB.
- ADDIWB: `regwrite`=1. Goes to FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1. Goes to FETCH.

Qualification rules:
- All outputs are decoded from the state register only.
- The only exceptions are FETCH `irwrite` and `pcwrite`, which are ANDed with `mem_ready`.
- The `op` value sampled in DECODE and MEMADR is the IR contents; the IR is stable because `irwrite` is 0 outside FETCH.

## Timing
- Reset: asserting `reset_n`=0 forces FETCH immediately and asynchronously, including mid-instruction (for example during MEMWR). The partial instruction is abandoned and `memwrite` drops combinationally.
- After reset release, the first fetch completes on the first edge with `mem_ready`=1.
- With `mem_ready` tied to 1, instruction cycle counts are:
  - LW: 5
  - SW, R-type, ADDI: 4
  - BEQ, J: 3
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle to that state.
- `state` updates on the rising edge of `clk`.

## Configuration
Macro: `MC_CTRL_ILLEGAL_TRAP_EN`.
- Defined:
  - An undefined `op` in DECODE goes to TRAP.
  - TRAP asserts `illegal_op`=1, holds all enables at 0, and is exited only by reset.
- Undefined:
  - An undefined `op` in DECODE returns to FETCH and is treated as a 2-cycle NOP.
  - The TRAP state and the `illegal_op` port do not exist.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the `statetype` enum (4-bit)
  - the opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - a packed struct for the 15-bit control word.
- Sub-module `mc_ctrl_outdec` is the combinational decoder from state to control word.
- The top level holds the state register, the next-state logic and the `mem_ready` qualification.

## Test plan
- Reset and stall: hold `reset_n`=0, then release with `mem_ready`=0 for 3 cycles. Required: `state`=FETCH and `irwrite`=`pcwrite`=0 throughout; DECODE on the first edge after `mem_ready`=1.
- Opcode paths: `mem_ready`=1, each `op` in turn (000000, 100011, 101011, 000100, 001000, 000010). Required: cycle counts 4, 5, 4, 3, 4, 3 and the exact per-state control words above.
- Slow memory: `op`=LW with `mem_ready` low for 2 cycles in MEMRD. Required: 7 cycles total, with `regwrite` high only in the MEMWB cycle.
- Reset during store: assert `reset_n`=0 in MEMWR. Required: `memwrite` falls to 0 the same cycle and `state`=FETCH.
- Illegal opcode: `op`=111111.
  - With the macro defined: TRAP with `illegal_op`=1, held for 10 cycles.
  - Without the macro: FETCH on the cycle after DECODE.
- Opcode change mid-instruction: change `op` after the FETCH edge. Required: no effect before the next FETCH, because `irwrite` is 0.
